// File: rtl/add_result_checker.sv
// Scoreboard for an adder DUT: predicts (a+b) mod 2^WIDTH, delays the prediction
// by the DUT latency, compares it with res_i and keeps pass/fail statistics.
module add_result_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] res_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic [WIDTH-1:0] first_exp_o,
    output logic [WIDTH-1:0] first_got_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [LATENCY-1:0]            pipe_vld_q;
    logic [LATENCY-1:0][WIDTH-1:0] pipe_exp_q;
    logic [LATENCY:0]              vld_ext;
    logic [LATENCY:0][WIDTH-1:0]   exp_ext;

    logic             enter_run;
    logic             stage0_vld;
    logic [WIDTH-1:0] sum;
    logic             cmp_valid;
    logic [WIDTH-1:0] cmp_exp;
    logic             cmp_match;

    // The carry-out is dropped by the WIDTH-bit sum, matching the DUT's modulo behaviour
    assign sum        = a_i + b_i;
    assign enter_run  = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign stage0_vld = in_valid_i && (state_q == RUN);
    assign vld_ext    = {pipe_vld_q, stage0_vld};
    assign exp_ext    = {pipe_exp_q, sum};
    assign cmp_valid  = pipe_vld_q[LATENCY-1];
    assign cmp_exp    = pipe_exp_q[LATENCY-1];
    assign cmp_match  = (cmp_exp == res_i);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (stop_i) state_d = DRAIN;
            DRAIN:   if (pipe_vld_q == '0) state_d = DONE;
            DONE:    if (start_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == RUN) || (state_q == DRAIN);
        done_o = (state_q == DONE);
    end

    // Extended vectors put the new stage-0 entry below the existing stages, so the
    // same shift works for LATENCY == 1
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pipe_vld_q <= '0;
            pipe_exp_q <= '0;
        end else begin
            pipe_exp_q <= exp_ext[LATENCY-1:0];
            if (enter_run) begin
                pipe_vld_q <= '0;
            end else begin
                pipe_vld_q <= vld_ext[LATENCY-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            err_o       <= 1'b0;
            first_exp_o <= '0;
            first_got_o <= '0;
        end else if (enter_run) begin
            pass_cnt_o  <= '0;
            fail_cnt_o  <= '0;
            err_o       <= 1'b0;
            first_exp_o <= '0;
            first_got_o <= '0;
        end else if (cmp_valid) begin
            if (cmp_match) begin
                if (pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + CNT_W'(1);
            end else begin
                err_o <= 1'b1;
                if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + CNT_W'(1);
                if (fail_cnt_o == '0) begin
                    first_exp_o <= cmp_exp;
                    first_got_o <= res_i;
                end
            end
        end
    end

endmodule

// File: doc/add_result_checker.md
# add_result_checker

Receive-side companion to the adder stimulus driver. It observes the operands applied to the adder DUT and the DUT's `res` output, and predicts each sum modulo 2^WIDTH. It compares each prediction against the DUT output after the DUT's fixed pipeline latency and accumulates pass/fail statistics for the testbench. It sits in the bench next to the DUT, driven by the same clock, and reports a done/error status for end-of-test decisions.

## Interface
- `WIDTH`, 8, operand and result width.
- `LATENCY`, 1, DUT cycles from operand application to valid result; legal range 1..16.
- `CNT_W`, 16, pass/fail counter width.

- `clk_i`  in  1  bench clock; all state updates on the rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  single-cycle pulse: clear statistics, begin checking.
- `stop_i`  in  1  single-cycle pulse: stop accepting samples, drain, then finish.
- `in_valid_i`  in  1  `a_i`/`b_i` are being applied to the DUT this cycle.
- `a_i`  in  WIDTH  operand A as driven to DUT `io_A`.
- `b_i`  in  WIDTH  operand B as driven to DUT `io_B`.
- `res_i`  in  WIDTH  DUT `io_X`.
- `busy_o`  out  1  state is RUN or DRAIN.
- `done_o`  out  1  state is DONE.
- `err_o`  out  1  sticky: at least one mismatch since `start_i`.
- `pass_cnt_o`  out  CNT_W  matching compares.
- `fail_cnt_o`  out  CNT_W  mismatching compares.
- `first_exp_o`  out  WIDTH  expected value of the first mismatch.
- `first_got_o`  out  WIDTH  DUT value of the first mismatch.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start_i`. `stop_i` is ignored in IDLE.
  - RUN → DRAIN on `stop_i`.
  - DRAIN → DONE when the prediction pipeline holds no valid entry.
  - DONE → RUN on `start_i`.
  - `start_i` in RUN or DRAIN is ignored.
- Entering RUN clears all counters, `err_o`, `first_exp_o`, `first_got_o`, and all prediction-pipeline valid bits.
- Prediction pipeline: LATENCY stages, each holding {valid, expected}.
  - Stage 0 loads {`in_valid_i` && state==RUN, (`a_i`+`b_i`) mod 2^WIDTH}. The carry-out is discarded.
  - Each following stage shifts every cycle.
- Compare: when the last stage is valid, `expected` is compared with `res_i` in that same cycle. Compares also occur in DRAIN.
  - Match: `pass_cnt` +1.
  - Mismatch: `fail_cnt` +1 and `err_o` set. If `fail_cnt` was 0, capture `first_exp_o`/`first_got_o`.
- Counters saturate at 2^CNT_W−1 and never wrap. `err_o` stays set even when `fail_cnt` is saturated.
- `in_valid_i` together with `stop_i` in RUN: that sample is accepted and checked.
- `in_valid_i` outside RUN: ignored, and no compare is scheduled for it.
- `stop_i` with an empty pipeline: DRAIN lasts exactly one cycle, then DONE.

## Timing
- Reset values (async, while `reset_ni`=0): state IDLE, all pipeline valids 0, every output 0.
- Reset asserted mid-RUN or mid-DRAIN: all outputs drop to 0 immediately, without waiting for a clock edge. On release, the block sits in IDLE; no stale compares occur.
- Sample accepted at edge t → compared against `res_i` sampled at edge t+LATENCY → counters/`err_o` visible after edge t+LATENCY.
- `stop_i` at edge s with the last valid sample accepted at edge s → `done_o` rises after edge s+LATENCY+1.
- Back-to-back `in_valid_i` every cycle is supported; throughput is 1 compare per cycle.

## Test plan
- Reset, `start_i`, 4 samples (1+2, 100+27, 200+100, 255+1) with a correct DUT model, LATENCY=1, then `stop_i` → `pass_cnt_o`=4, `fail_cnt_o`=0, `err_o`=0, `done_o` high 2 cycles after `stop_i`.
- Same sequence with `res_i` forced to 0x00 on the second compare → `fail_cnt_o`=1, `pass_cnt_o`=3, `err_o`=1, `first_exp_o`=0x7F, `first_got_o`=0x00.
- Wrap: 255+1 and 128+128 → expected 0x00 for both, both counted as passes.
- LATENCY=3, 10 back-to-back samples followed immediately by `stop_i` → all 10 compared, `pass_cnt_o`=10, DONE reached 4 cycles after `stop_i`.
- Assert `reset_ni` low mid-RUN after 2 compares, release, give no `start_i`, then apply `in_valid_i` for 5 cycles → all outputs remain 0 and the state stays IDLE.
- CNT_W=4, 20 matching samples → `pass_cnt_o` saturates at 15. In a separate run, DONE followed by `start_i` clears the counters and `err_o`.
